// File: rtl/pi_angle_pkg.sv
// Shared definitions for the Pi angle-sample controller:
// register addresses, CTRL/STATUS bit positions and handshake FSM states.
package pi_angle_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_TRIG   = 2;
    localparam int CTRL_CLR    = 3;

    localparam int ST_NEW      = 0;
    localparam int ST_OVERRUN  = 1;
    localparam int ST_TIMEOUT  = 2;
    localparam int ST_STATE    = 3;
    localparam int ST_COUNT    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } hs_state_e;

endpackage

// File: rtl/pi_angle_sample_ctrl_if.sv
// Avalon-MM register bus of the angle-sample controller.
// master: host side (drives address/read/write/writedata); slave: controller.
interface pi_angle_sample_ctrl_if;

    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/pi_angle_hs_fsm.sv
// 4-phase req/ack handshake engine with ack synchroniser and wait timeout.
// Ports: trigger_i starts a handshake from IDLE; ext_ack_i raw producer ack;
// ext_req_o request; latch_o one-cycle data-capture pulse; busy_o not IDLE;
// timeout_o one-cycle abort pulse; state_o current state code.
module pi_angle_hs_fsm
    import pi_angle_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trigger_i,
    input  logic       ext_ack_i,
    output logic       ext_req_o,
    output logic       latch_o,
    output logic       busy_o,
    output logic       timeout_o,
    output logic [1:0] state_o
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              ack_meta_q;
    logic              ack_sync_q;
    hs_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              req_q, req_d;
    logic              expire;

    // Last permitted cycle in a wait state; the abort takes effect on it.
    assign expire = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        req_d     = req_q;
        latch_o   = 1'b0;
        timeout_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (trigger_i) begin
                    state_d = REQ;
                    wait_d  = '0;
                    req_d   = 1'b1;
                end
            end
            REQ: begin
                if (ack_sync_q) begin
                    latch_o = 1'b1;
                    req_d   = 1'b0;
                    wait_d  = '0;
                    state_d = REL;
                end else if (expire) begin
                    timeout_o = 1'b1;
                    req_d     = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            REL: begin
                req_d = 1'b0;
                if (!ack_sync_q) begin
                    state_d = IDLE;
                end else if (expire) begin
                    timeout_o = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
            state_q    <= IDLE;
            wait_q     <= '0;
            req_q      <= 1'b0;
        end else begin
            ack_meta_q <= ext_ack_i;
            ack_sync_q <= ack_meta_q;
            state_q    <= state_d;
            wait_q     <= wait_d;
            req_q      <= req_d;
        end
    end

    assign ext_req_o = req_q;
    assign busy_o    = (state_q != IDLE);
    assign state_o   = state_q;

endmodule

// File: rtl/pi_angle_sample_ctrl.sv
// Avalon-MM slave that acquires handshake-qualified angle samples.
// Ports: bus register interface (DATA/STATUS/CTRL/PERIOD, irq);
// ext_req/ext_ack/ext_data link to the Raspberry Pi producer.
module pi_angle_sample_ctrl
    import pi_angle_pkg::*;
#(
    parameter int unsigned PERIOD_DEFAULT = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pi_angle_sample_ctrl_if.slave bus,
    output logic                  ext_req,
    input  logic                  ext_ack,
    input  logic [31:0]           ext_data
);

    logic [31:0]      data_q, data_d;
    logic             new_q, new_d;
    logic             ovr_q, ovr_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic [31:0]      period_q, period_d;
    logic [31:0]      pcnt_q, pcnt_d;
    logic             reload_q, reload_d;
    logic [31:0]      readdata_q, readdata_d;

    logic        wr_ctrl, wr_period, rd_data;
    logic        trig_wr, clr_wr, tick, trigger;
    logic        fsm_latch, fsm_busy, fsm_timeout;
    logic [1:0]  fsm_state;
    logic [31:0] status_w;

    pi_angle_hs_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hs_fsm (
        .clk       (clk),
        .reset_n   (reset_n),
        .trigger_i (trigger),
        .ext_ack_i (ext_ack),
        .ext_req_o (ext_req),
        .latch_o   (fsm_latch),
        .busy_o    (fsm_busy),
        .timeout_o (fsm_timeout),
        .state_o   (fsm_state)
    );

    always_comb begin
        wr_ctrl   = bus.write && (bus.address == ADDR_CTRL);
        wr_period = bus.write && (bus.address == ADDR_PERIOD);
        rd_data   = bus.read && (bus.address == ADDR_DATA);
        trig_wr   = wr_ctrl && bus.writedata[CTRL_TRIG];
        clr_wr    = wr_ctrl && bus.writedata[CTRL_CLR];
        // Counter is reloaded on the cycle after a PERIOD write, so no tick then.
        tick      = en_q && !reload_q && (pcnt_q == '0);
        trigger   = tick || trig_wr;
    end

    always_comb begin
        status_w                       = '0;
        status_w[ST_NEW]               = new_q;
        status_w[ST_OVERRUN]           = ovr_q;
        status_w[ST_TIMEOUT]           = tmo_q;
        status_w[ST_STATE +: 2]        = fsm_state;
        status_w[ST_COUNT +: CNT_W]    = cnt_q;
    end

    always_comb begin
        data_d     = fsm_latch ? ext_data : data_q;
        // Flag sets take priority over clears in the same cycle.
        new_d      = fsm_latch ? 1'b1 : (rd_data ? 1'b0 : new_q);
        ovr_d      = (trigger && fsm_busy) ? 1'b1 : (clr_wr ? 1'b0 : ovr_q);
        tmo_d      = fsm_timeout ? 1'b1 : (clr_wr ? 1'b0 : tmo_q);
        cnt_d      = fsm_latch ? cnt_q + CNT_W'(1) : cnt_q;
        en_d       = wr_ctrl ? bus.writedata[CTRL_ENABLE] : en_q;
        irq_en_d   = wr_ctrl ? bus.writedata[CTRL_IRQ_EN] : irq_en_q;
        period_d   = period_q;
        if (wr_period) begin
            period_d = (bus.writedata == '0) ? 32'd1 : bus.writedata;
        end
        reload_d   = wr_period;
        // Reloading with PERIOD-1 gives exactly PERIOD cycles between ticks.
        if (!en_q || reload_q || (pcnt_q == '0)) begin
            pcnt_d = period_q - 32'd1;
        end else begin
            pcnt_d = pcnt_q - 32'd1;
        end
        readdata_d = readdata_q;
        if (bus.read) begin
            unique case (bus.address)
                ADDR_DATA:   readdata_d = data_q;
                ADDR_STATUS: readdata_d = status_w;
                ADDR_CTRL:   readdata_d = {30'd0, irq_en_q, en_q};
                ADDR_PERIOD: readdata_d = period_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            new_q      <= 1'b0;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= 32'(PERIOD_DEFAULT);
            pcnt_q     <= 32'(PERIOD_DEFAULT - 1);
            reload_q   <= 1'b0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            new_q      <= new_d;
            ovr_q      <= ovr_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            period_q   <= period_d;
            pcnt_q     <= pcnt_d;
            reload_q   <= reload_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = new_q & irq_en_q;

endmodule
